// File: rtl/sram_sdp_clr_if.sv
// ---------------------------------------------------------------------------
// sram_sdp_clr_if
// Request/response bundle for the simple-dual-port SRAM with clear engine.
//   clr       : start a clear sweep (honoured only while idle)
//   wr_en     : write strobe, wr_addr / wr_data qualify it
//   rd_en     : read strobe, rd_addr qualifies it
//   rd_data   : registered read data (latency 1)
//   rd_valid  : rd_data carries a read issued on the previous edge
//   busy      : clear sweep in progress, all requests dropped
//   clr_done  : one-cycle pulse on the first idle cycle after a sweep
// master = requester, slave = memory.
// ---------------------------------------------------------------------------
interface sram_sdp_clr_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
);
    logic              clr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic              clr_done;

    modport master (
        output clr, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid, busy, clr_done
    );

    modport slave (
        input  clr, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid, busy, clr_done
    );
endinterface

// File: rtl/sram_sdp_clr.sv
// ---------------------------------------------------------------------------
// sram_sdp_clr
// Simple-dual-port synchronous SRAM (one write port, one read port) with a
// registered read + valid strobe, write-first forwarding on same-address
// collisions, and a clear engine that sweeps CLR_VAL into every word.
//
// Ports:
//   clk      : system clock, all state changes on the rising edge
//   reset_p  : asynchronous active-high reset (array contents not reset)
//   bus      : sram_sdp_clr_if.slave (clr, write port, read port, status)
//
// Parameters:
//   DATA_W     : word width
//   ADDR_W     : address width, DEPTH = 2**ADDR_W
//   CLR_VAL    : fill word used by the clear sweep
//   CLR_ON_RST : 1 = leaving reset starts a sweep, 0 = leaving reset is idle
// ---------------------------------------------------------------------------
module sram_sdp_clr #(
    parameter int                DATA_W     = 8,
    parameter int                ADDR_W     = 10,
    parameter logic [DATA_W-1:0] CLR_VAL    = '0,
    parameter bit                CLR_ON_RST = 1'b1
) (
    input  logic          clk,
    input  logic          reset_p,
    sram_sdp_clr_if.slave bus
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_LAST = '1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] ptr_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic              rd_valid_reg;
    logic              clr_done_reg;

    logic [DATA_W-1:0] mem [DEPTH];

    // Single write port shared by the clear engine and the user write.
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              req_ok;
    logic              rd_fwd;

    always_comb begin
        // A clr request takes the whole cycle: same-cycle reads/writes drop.
        req_ok    = (state_reg == ST_IDLE) && !bus.clr;
        rd_fwd    = bus.wr_en && (bus.wr_addr == bus.rd_addr);
        mem_we    = 1'b0;
        mem_waddr = bus.wr_addr;
        mem_wdata = bus.wr_data;
        if (state_reg == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_reg;
            mem_wdata = CLR_VAL;
        end else if (req_ok && bus.wr_en) begin
            mem_we = 1'b1;
        end
    end

    // Array has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Control FSM plus registered read port.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            if (CLR_ON_RST) begin
                state_reg <= ST_CLEAR;
            end else begin
                state_reg <= ST_IDLE;
            end
            ptr_reg      <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
            clr_done_reg <= 1'b0;
        end else begin
            rd_valid_reg <= 1'b0;
            clr_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.clr) begin
                        state_reg <= ST_CLEAR;
                        ptr_reg   <= '0;
                    end else if (bus.rd_en) begin
                        rd_valid_reg <= 1'b1;
                        // Write-first: a colliding write is seen by the read.
                        rd_data_reg  <= rd_fwd ? bus.wr_data : mem[bus.rd_addr];
                    end
                end
                ST_CLEAR: begin
                    // Terminal count on the last word; never wraps past it.
                    if (ptr_reg == PTR_LAST) begin
                        state_reg    <= ST_IDLE;
                        ptr_reg      <= '0;
                        clr_done_reg <= 1'b1;
                    end else begin
                        ptr_reg <= ptr_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    ptr_reg   <= '0;
                end
            endcase
        end
    end

    assign bus.busy     = (state_reg == ST_CLEAR);
    assign bus.rd_data  = rd_data_reg;
    assign bus.rd_valid = rd_valid_reg;
    assign bus.clr_done = clr_done_reg;

endmodule
